// File: rtl/sub_digit_serial_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
// The slave side is the subtractor; the master side feeds operands and drains results.
interface sub_digit_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out, zero, overflow
    );
endinterface

// File: rtl/sub_digit_serial.sv
// Digit-serial subtractor: a - b - b_in, one DIGIT-wide borrow-lookahead slice per cycle,
// least-significant digit first, with valid/ready handshakes on both sides.
module sub_digit_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    sub_digit_serial_if.slave bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [WIDTH-1:0]  diff_d;
    logic              borrow_q;
    logic              b_out_q;
    logic              zero_q;
    logic              ovf_q;

    int unsigned       base;
    logic [DIGIT-1:0]  x;
    logic [DIGIT-1:0]  y;
    logic [DIGIT-1:0]  g;
    logic [DIGIT-1:0]  p;
    logic [DIGIT-1:0]  dig;
    logic [DIGIT:0]    bor;
    logic              last;

    // Borrow chain for the current digit; bor[i] is the borrow into bit i of the digit.
    always_comb begin
        base   = 32'(cnt_q) * DIGIT;
        x      = a_q[base +: DIGIT];
        y      = b_q[base +: DIGIT];
        g      = ~x & y;
        p      = ~x | y;
        bor    = '0;
        bor[0] = borrow_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            bor[i+1] = g[i] | (p[i] & bor[i]);
        end
        dig    = x ^ y ^ bor[DIGIT-1:0];
        diff_d = diff_q;
        diff_d[base +: DIGIT] = dig;
        last   = (cnt_q == CntW'(N - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.b_in;
                        cnt_q    <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    diff_q   <= diff_d;
                    borrow_q <= bor[DIGIT];
                    if (last) begin
                        cnt_q   <= '0;
                        b_out_q <= bor[DIGIT];
                        zero_q  <= (diff_d == '0);
                        // Signed overflow: borrow into the sign bit differs from borrow out.
                        ovf_q   <= bor[DIGIT-1] ^ bor[DIGIT];
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = diff_q;
    assign bus.b_out     = b_out_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sub_digit_serial.sv
// Directed bench for sub_digit_serial: hand-computed vectors, backpressure and mid-run reset.
module tb_sub_digit_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sub_digit_serial_if #(.WIDTH(16)) bus ();

    sub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input logic bo,
                                input logic z, input logic ov);
        chk({tag, " diff"}, 32'(bus.diff), 32'(d));
        chk({tag, " b_out"}, 32'(bus.b_out), 32'(bo));
        chk({tag, " zero"}, 32'(bus.zero), 32'(z));
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(ov));
    endtask

    // Present one operand set, accept it, and confirm out_valid appears exactly 4 edges later.
    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic bi);
        chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.b_in     = bi;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.b_in     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            if (i == 4) tick();
            chk({tag, " out_valid latency"}, 32'(bus.out_valid), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input logic [15:0] d, input logic bo,
                          input logic z, input logic ov);
        bus.out_ready = 1'b1;
        start_op(tag, av, bv, bi);
        check_result(tag, d, bo, z, ov);
        tick();
        chk({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " in_ready return"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.b_in      = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_result("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("bin_zero", 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("both", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);

        // Backpressure: result held for 5 cycles while a stray in_valid is ignored.
        bus.out_ready = 1'b0;
        start_op("bp", 16'h00FF, 16'h0F0F, 1'b0);
        check_result("bp first", 16'hF1F0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 1);
            bus.a        = 16'h1111;
            bus.b        = 16'h2222;
            tick();
            chk("bp out_valid held", 32'(bus.out_valid), 32'd1);
            chk("bp in_ready low", 32'(bus.in_ready), 32'd0);
            check_result("bp hold", 16'hF1F0, 1'b1, 1'b0, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        run_op("bp next", 16'h9000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);

        // Reset sampled at the edge ending the 2nd RUN cycle.
        bus.a        = 16'hFFFF;
        bus.b        = 16'h0001;
        bus.b_in     = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst mid out_valid", 32'(bus.out_valid), 32'd0);
        check_result("rst mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst no out_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op("after rst", 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
